chan_mailbox: RTL

//  Dispatcher-side channel store; consumes the CPU_R_CHAN_SET / CPU_R_CHAN_DEL requests

---
 rtl/chan_mailbox.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/chan_mailbox.sv
// chan_mailbox: dispatcher-side store of one-deep message channels.
// Parks CHAN_SET values by channel id and returns them on the next SET or a DEL.
module chan_mailbox #(
  parameter int ENTRIES      = 8,
  parameter int IDX_W        = 3,
  parameter int CPU_MSG_SIZE = 4,
  parameter int ADDR_SIZE    = 8,
  parameter int DATA_SIZE    = 16,
  parameter logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_SET = CPU_MSG_SIZE'(5),
  parameter logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_DEL = CPU_MSG_SIZE'(6)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_oe,
  input  logic                    req_pulse,
  input  logic [CPU_MSG_SIZE-1:0] req_msg,
  input  logic [ADDR_SIZE-1:0]    req_addr,
  input  logic [DATA_SIZE-1:0]    req_data,
  output logic                    busy,
  output logic [CPU_MSG_SIZE-1:0] rsp_msg,
  output logic [ADDR_SIZE-1:0]    rsp_addr,
  output logic [DATA_SIZE-1:0]    rsp_data,
  output logic                    err_full,
  output logic [IDX_W:0]          chan_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP
  } state_t;

  state_t state_q;

  logic [ENTRIES-1:0]   slot_valid_q;
  logic [ENTRIES-1:0]   slot_full_q;
  logic [ADDR_SIZE-1:0] slot_addr_q [ENTRIES];
  logic [DATA_SIZE-1:0] slot_data_q [ENTRIES];

  logic                    op_set_q;
  logic [ADDR_SIZE-1:0]    op_addr_q;
  logic [DATA_SIZE-1:0]    op_data_q;

  logic                    busy_q;
  logic [CPU_MSG_SIZE-1:0] rsp_msg_q;
  logic [ADDR_SIZE-1:0]    rsp_addr_q;
  logic [DATA_SIZE-1:0]    rsp_data_q;
  logic                    err_full_q;
  logic [IDX_W:0]          count_q;

  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic             req_ok;

  assign req_ok = req_pulse &&
    (req_msg == CPU_R_CHAN_SET || req_msg == CPU_R_CHAN_DEL);

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (slot_valid_q[i] && slot_addr_q[i] == op_addr_q) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!slot_valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(negedge clk) begin
    if (clk_oe) begin
      if (rst) begin
        state_q      <= S_IDLE;
        slot_valid_q <= '0;
        slot_full_q  <= '0;
        for (int i = 0; i < ENTRIES; i++) begin
          slot_addr_q[i] <= '0;
          slot_data_q[i] <= '0;
        end
        op_set_q   <= 1'b0;
        op_addr_q  <= '0;
        op_data_q  <= '0;
        busy_q     <= 1'b0;
        rsp_msg_q  <= '0;
        rsp_addr_q <= '0;
        rsp_data_q <= '0;
        err_full_q <= 1'b0;
        count_q    <= '0;
      end else begin
        rsp_msg_q  <= '0;
        rsp_addr_q <= '0;
        rsp_data_q <= '0;
        err_full_q <= 1'b0;
        unique case (state_q)
          S_IDLE: begin
            if (req_ok) begin
              op_set_q  <= (req_msg == CPU_R_CHAN_SET);
              op_addr_q <= req_addr;
              op_data_q <= req_data;
              busy_q    <= 1'b1;
              state_q   <= S_LOOKUP;
            end
          end
          S_LOOKUP: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (op_set_q) begin
              if (hit_any) begin
                slot_data_q[hit_idx] <= op_data_q;
                slot_full_q[hit_idx] <= 1'b1;
                if (slot_full_q[hit_idx]) begin
                  rsp_msg_q  <= CPU_R_CHAN_SET;
                  rsp_addr_q <= op_addr_q;
                  rsp_data_q <= slot_data_q[hit_idx];
                  busy_q     <= 1'b1;
                  state_q    <= S_RESP;
                end
              end else if (free_any) begin
                slot_valid_q[free_idx] <= 1'b1;
                slot_full_q[free_idx]  <= 1'b1;
                slot_addr_q[free_idx]  <= op_addr_q;
                slot_data_q[free_idx]  <= op_data_q;
                count_q <= count_q + (IDX_W+1)'(1);
              end else begin
                err_full_q <= 1'b1;
              end
            end else if (hit_any) begin
              rsp_msg_q  <= CPU_R_CHAN_SET;
              rsp_addr_q <= op_addr_q;
              rsp_data_q <= slot_full_q[hit_idx] ?
                            slot_data_q[hit_idx] : '0;
              slot_valid_q[hit_idx] <= 1'b0;
              slot_full_q[hit_idx]  <= 1'b0;
              count_q <= count_q - (IDX_W+1)'(1);
              busy_q  <= 1'b1;
              state_q <= S_RESP;
            end
          end
          S_RESP: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pulses read as zero while updates are disabled.
  assign busy       = busy_q;
  assign rsp_msg    = clk_oe ? rsp_msg_q  : '0;
  assign rsp_addr   = clk_oe ? rsp_addr_q : '0;
  assign rsp_data   = clk_oe ? rsp_data_q : '0;
  assign err_full   = clk_oe & err_full_q;
  assign chan_count = count_q;

endmodule
